// File: rtl/twiddle_cmul3_pkg.sv
// Shared FFT-stage definitions: coefficient format, index-width helper,
// K0/K1/K2 select encoding and the coefficient-load FSM states.
package twiddle_cmul3_pkg;

  // Significant coefficient bits and their fractional bits (127 ~ 1.0).
  localparam int unsigned CW   = 9;
  localparam int unsigned FRAC = 7;

  // Mapper select encoding for the three stored coefficients.
  typedef enum logic [1:0] {
    SelK0 = 2'd0,
    SelK1 = 2'd1,
    SelK2 = 2'd2
  } coef_sel_e;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StReady,
    StErr
  } load_st_e;

  // Width of a twiddle index addressing N/2 table entries.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n / 2 > 1) ? $clog2(n / 2) : 1;
  endfunction

endpackage

// File: rtl/twiddle_cmul3_pipe.sv
// Three-stage complex multiply of (a + jb) by W = C - jS using three real
// multipliers and the precomputed coefficients K0 = C, K1 = C + S, K2 = C - S.
//   clk, rst          : clock, asynchronous active-high reset
//   in_valid          : sample strobe (already qualified by the table state)
//   a, b              : sample real / imaginary parts
//   k0, k1, k2        : coefficient triple for this sample
//   out_valid         : result strobe, three cycles after acceptance
//   out_re, out_im    : floor((C*a + S*b) / 2^FRAC), floor((C*b - S*a) / 2^FRAC)
module cmul3_pipe #(
  parameter int unsigned DW   = 16,
  parameter int unsigned CW   = twiddle_cmul3_pkg::CW,
  parameter int unsigned FRAC = twiddle_cmul3_pkg::FRAC
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  input  logic signed [CW-1:0] k0,
  input  logic signed [CW-1:0] k1,
  input  logic signed [CW-1:0] k2,
  output logic                 out_valid,
  output logic signed [DW:0]   out_re,
  output logic signed [DW:0]   out_im
);

  localparam int unsigned PW  = DW + 1 + CW;  // full product width
  localparam int unsigned DFW = PW + 1;       // difference cannot overflow

  logic                 v1_q, v2_q;
  logic signed [DW-1:0] a_q, b_q;
  logic signed [DW:0]   s_q;
  logic signed [CW-1:0] k0_q, k1_q, k2_q;
  logic signed [PW-1:0] t_q, p_q, q_q;
  logic signed [DFW-1:0] re_full, im_full;

  // re = K0*(a+b) - b*K2 = C*a + S*b ; im = K0*(a+b) - a*K1 = C*b - S*a
  always_comb begin
    re_full = (DFW'(t_q) - DFW'(p_q)) >>> FRAC;
    im_full = (DFW'(t_q) - DFW'(q_q)) >>> FRAC;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      out_valid <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      s_q       <= '0;
      k0_q      <= '0;
      k1_q      <= '0;
      k2_q      <= '0;
      t_q       <= '0;
      p_q       <= '0;
      q_q       <= '0;
      out_re    <= '0;
      out_im    <= '0;
    end else begin
      // Stage 1: operands and pre-add
      v1_q <= in_valid;
      a_q  <= a;
      b_q  <= b;
      s_q  <= (DW + 1)'(a) + (DW + 1)'(b);
      k0_q <= k0;
      k1_q <= k1;
      k2_q <= k2;
      // Stage 2: three real products
      v2_q <= v1_q;
      t_q  <= PW'(s_q) * PW'(k0_q);
      p_q  <= PW'(b_q) * PW'(k2_q);
      q_q  <= PW'(a_q) * PW'(k1_q);
      // Stage 3: combine, floor-scale and truncate
      out_valid <= v2_q;
      out_re    <= re_full[DW:0];
      out_im    <= im_full[DW:0];
    end
  end

endmodule

// File: rtl/twiddle_cmul3.sv
// FFT-stage twiddle multiplier. Captures the coefficient mapper's stream into a
// table of N/2 (K0, K1, K2) triples, then multiplies samples by W[k] = C - jS.
//   clk, rst            : clock, asynchronous active-high reset
//   c_we, c_sel, c_data : mapper write strobe, K select, data (data lags by one)
//   c_dv                : mapper load-done pulse
//   table_ready         : a complete table is loaded
//   load_err            : sticky, load finished with fewer than N/2 triples
//   in_valid, in_ready  : sample strobe / accept (in_ready == table_ready)
//   in_re, in_im        : signed sample
//   tw_idx              : twiddle index k
//   out_valid           : result strobe, 3 cycles after acceptance
//   out_re, out_im      : signed result, DW+1 bits
module twiddle_cmul3 #(
  parameter int unsigned N    = 16,
  parameter int unsigned MSB  = 16,
  parameter int unsigned CW   = twiddle_cmul3_pkg::CW,
  parameter int unsigned DW   = 16,
  parameter int unsigned FRAC = twiddle_cmul3_pkg::FRAC
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           c_we,
  input  logic [1:0]                                     c_sel,
  input  logic [MSB-1:0]                                 c_data,
  input  logic                                           c_dv,
  output logic                                           table_ready,
  output logic                                           load_err,
  input  logic                                           in_valid,
  output logic                                           in_ready,
  input  logic signed [DW-1:0]                           in_re,
  input  logic signed [DW-1:0]                           in_im,
  input  logic [twiddle_cmul3_pkg::idx_width(N)-1:0]     tw_idx,
  output logic                                           out_valid,
  output logic signed [DW:0]                             out_re,
  output logic signed [DW:0]                             out_im
);

  import twiddle_cmul3_pkg::*;

  localparam int unsigned Half = N / 2;
  localparam int unsigned Iw   = idx_width(N);

  logic          d_we;
  logic [1:0]    d_sel;
  logic [Iw:0]   idx_q, idx_d;
  load_st_e      st_q, st_d;
  logic          we_rise, wr_en, full;

  logic signed [CW-1:0] coef_k0 [Half];
  logic signed [CW-1:0] coef_k1 [Half];
  logic signed [CW-1:0] coef_k2 [Half];

  logic unused_hi;
  assign unused_hi = ^c_data[MSB-1:CW];

  assign we_rise = c_we & ~d_we;
  // Writes past the last triple (mapper's duplicate select-2) and select 3 are dropped.
  assign wr_en   = d_we && (idx_q < (Iw + 1)'(Half)) && (d_sel != 2'd3);
  assign full    = (idx_q == (Iw + 1)'(Half));

  always_comb begin
    st_d  = st_q;
    idx_d = idx_q;
    if (we_rise) begin
      // A new load outranks a coincident c_dv.
      st_d  = StLoad;
      idx_d = '0;
    end else begin
      if (wr_en && (d_sel == SelK2)) idx_d = idx_q + 1'b1;
      if (c_dv) st_d = full ? StReady : StErr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_we  <= 1'b0;
      d_sel <= 2'd0;
      idx_q <= '0;
      st_q  <= StIdle;
    end else begin
      d_we  <= c_we;
      d_sel <= c_sel;
      idx_q <= idx_d;
      st_q  <= st_d;
    end
  end

  // Table contents are not reset; a full reload is required after reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      case (d_sel)
        SelK0:   coef_k0[idx_q[Iw-1:0]] <= c_data[CW-1:0];
        SelK1:   coef_k1[idx_q[Iw-1:0]] <= c_data[CW-1:0];
        SelK2:   coef_k2[idx_q[Iw-1:0]] <= c_data[CW-1:0];
        default: ;
      endcase
    end
  end

  assign table_ready = (st_q == StReady);
  assign load_err    = (st_q == StErr);
  assign in_ready    = table_ready;

  cmul3_pipe #(
    .DW   (DW),
    .CW   (CW),
    .FRAC (FRAC)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid && in_ready),
    .a         (in_re),
    .b         (in_im),
    .k0        (coef_k0[tw_idx]),
    .k1        (coef_k1[tw_idx]),
    .k2        (coef_k2[tw_idx]),
    .out_valid (out_valid),
    .out_re    (out_re),
    .out_im    (out_im)
  );

endmodule

// File: tb/tb_twiddle_cmul3.sv
module tb_twiddle_cmul3;

  logic               clk;
  logic               rst;
  logic               c_we;
  logic [1:0]         c_sel;
  logic [15:0]        c_data;
  logic               c_dv;
  logic               table_ready;
  logic               load_err;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_re;
  logic signed [15:0] in_im;
  logic [2:0]         tw_idx;
  logic               out_valid;
  logic signed [16:0] out_re;
  logic signed [16:0] out_im;

  int n_chk = 0;
  int n_err = 0;

  // Q7 cos / sin of 2*pi*k/16, truncated toward zero.
  int c_tab [8] = '{127, 117, 89, 48, 0, -48, -89, -117};
  int s_tab [8] = '{0, 48, 89, 117, 127, 117, 89, 48};

  twiddle_cmul3 #(
    .N    (16),
    .MSB  (16),
    .CW   (9),
    .DW   (16),
    .FRAC (7)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .c_we        (c_we),
    .c_sel       (c_sel),
    .c_data      (c_data),
    .c_dv        (c_dv),
    .table_ready (table_ready),
    .load_err    (load_err),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_re       (in_re),
    .in_im       (in_im),
    .tw_idx      (tw_idx),
    .out_valid   (out_valid),
    .out_re      (out_re),
    .out_im      (out_im)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] coef_word(input int k, input int sel);
    int v;
    case (sel)
      0:       v = c_tab[k];
      1:       v = c_tab[k] + s_tab[k];
      default: v = c_tab[k] - s_tab[k];
    endcase
    return 16'(v);
  endfunction

  function automatic int ref_re(input int k, input int a, input int b);
    return (c_tab[k] * a + s_tab[k] * b) >>> 7;
  endfunction

  function automatic int ref_im(input int k, input int a, input int b);
    return (c_tab[k] * b - s_tab[k] * a) >>> 7;
  endfunction

  // Mapper model: data lags select by one cycle, final select-2 repeated, then c_dv.
  task automatic load_table(input int ntrip);
    logic [15:0] prev;
    prev = '0;
    for (int i = 0; i < 3 * ntrip; i++) begin
      c_we   = 1'b1;
      c_sel  = 2'(i % 3);
      c_data = prev;
      prev   = coef_word(i / 3, i % 3);
      step();
      if (i == 0) check("ready_fall", table_ready, 0);
    end
    c_we   = 1'b1;
    c_sel  = 2'd2;
    c_data = prev;
    step();
    c_we   = 1'b0;
    c_sel  = 2'd0;
    c_data = prev;
    c_dv   = 1'b1;
    step();
    c_dv   = 1'b0;
    c_data = '0;
  endtask

  task automatic idle_check(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      step();
      check(tag, out_valid, 0);
    end
  endtask

  task automatic single(input string tag, input int k, input int a, input int b,
                        input int exp_re, input int exp_im);
    tw_idx   = 3'(k);
    in_re    = 16'(a);
    in_im    = 16'(b);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check({tag, "_early"}, out_valid, 0);
    step();
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_re"}, out_re, exp_re);
    check({tag, "_im"}, out_im, exp_im);
    step();
    check({tag, "_pulse"}, out_valid, 0);
  endtask

  int b2b_a [8] = '{100, -200, 300, -400, 1234, -1000, 32767, -32768};
  int b2b_b [8] = '{-50, 75, 500, 0, -999, 2000, 32767, -32768};

  initial begin
    rst = 1'b1; c_we = 1'b0; c_sel = 2'd0; c_data = '0; c_dv = 1'b0;
    in_valid = 1'b0; in_re = '0; in_im = '0; tw_idx = '0;
    #1;
    check("rst_ready", table_ready, 0);
    check("rst_err", load_err, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_valid", out_valid, 0);
    check("rst_re", out_re, 0);
    check("rst_im", out_im, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // No table yet: sample must be dropped.
    tw_idx = 3'd0; in_re = 16'sd100; in_im = -16'sd50; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    idle_check("preload_drop", 4);

    load_table(8);
    check("load_ready", table_ready, 1);
    check("load_err", load_err, 0);
    check("load_in_ready", in_ready, 1);
    check("coef7_k0", dut.coef_k0[7], -117);
    check("coef7_k1", dut.coef_k1[7], -69);
    check("coef7_k2", dut.coef_k2[7], -165);

    single("k0", 0, 100, -50, 99, -50);
    single("k4", 4, 100, 0, 0, -100);

    // Back-to-back stream, one result per cycle.
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        tw_idx = 3'(c); in_re = 16'(b2b_a[c]); in_im = 16'(b2b_b[c]); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (c >= 2) begin
        check($sformatf("b2b%0d_valid", c - 2), out_valid, 1);
        check($sformatf("b2b%0d_re", c - 2), out_re, ref_re(c - 2, b2b_a[c - 2], b2b_b[c - 2]));
        check($sformatf("b2b%0d_im", c - 2), out_im, ref_im(c - 2, b2b_a[c - 2], b2b_b[c - 2]));
      end
    end
    step();
    check("b2b_end", out_valid, 0);

    // Short load: error flagged, inputs refused.
    load_table(5);
    check("short_err", load_err, 1);
    check("short_ready", table_ready, 0);
    check("short_in_ready", in_ready, 0);
    tw_idx = 3'd1; in_re = 16'sd200; in_im = 16'sd100; in_valid = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    idle_check("short_drop", 4);

    load_table(8);
    check("reload_err", load_err, 0);
    check("reload_ready", table_ready, 1);
    single("k1", 1, 200, 100, 220, 16);

    // Async reset with samples in flight.
    tw_idx = 3'd0; in_re = 16'sd100; in_im = 16'sd100; in_valid = 1'b1;
    step();
    tw_idx = 3'd2;
    step();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_ready", table_ready, 0);
    step();
    step();
    rst = 1'b0;
    idle_check("arst_drain", 5);
    check("arst_err", load_err, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
